// File: rtl/ldpc_ber_tester_pkg.sv
// Shared constants and types for the BER tester channel blocks: LLR width,
// per-lane seed spreading and xorshift32 shift amounts.
package ldpc_ber_tester_pkg;

  localparam int LLR_WIDTH = 8;

  localparam logic [31:0] LANE_SEED_STEP = 32'h9E3779B9;

  localparam int XS_SHIFT_A = 13;
  localparam int XS_SHIFT_B = 17;
  localparam int XS_SHIFT_C = 5;

  typedef logic signed [LLR_WIDTH-1:0] llr_t;

  // Golden-ratio spreading keeps neighbouring lanes decorrelated from one base seed.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned lane);
    logic [31:0] lane_idx;
    lane_idx = lane[31:0];
    return base ^ (lane_idx * LANE_SEED_STEP);
  endfunction

endpackage

// File: rtl/ldpc_ber_tester_xorshift32.sv
// One xorshift32 generator (13/17/5). Reset loads the seed; the state
// advances once per cycle in which advance is high.
module ldpc_ber_tester_xorshift32
  import ldpc_ber_tester_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_reg;
  logic [31:0] step_a;
  logic [31:0] step_b;
  logic [31:0] state_next;

  assign step_a     = state_reg ^ (state_reg << XS_SHIFT_A);
  assign step_b     = step_a ^ (step_a >> XS_SHIFT_B);
  assign state_next = step_b ^ (step_b << XS_SHIFT_C);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= seed;
    end else if (advance) begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/ldpc_ber_channel_flip.sv
// Seedable bit-error channel on the LLR stream: per-lane saturating negation
// with probability threshold/65536, two-entry skid buffer, flip counter
// (counter present only when LDPC_BER_FLIP_COUNT_EN is defined).
module ldpc_ber_channel_flip #(
  parameter logic [31:0] SEED       = 32'h1D872B41,
  parameter int          DATA_WIDTH = 128,
  parameter int          LLR_WIDTH  = ldpc_ber_tester_pkg::LLR_WIDTH
) (
  input  logic                  data_clk,
  input  logic                  data_resetn,
  input  logic                  en,
  input  logic [15:0]           threshold,
  input  logic                  clear_count,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [63:0]           flip_count
);

  import ldpc_ber_tester_pkg::*;

  localparam int N = DATA_WIDTH / LLR_WIDTH;
  localparam logic [LLR_WIDTH-1:0] MOST_NEG = {1'b1, {(LLR_WIDTH-1){1'b0}}};
  localparam logic [LLR_WIDTH-1:0] MOST_POS = {1'b0, {(LLR_WIDTH-1){1'b1}}};

  logic                  accept;
  logic [N-1:0]          flip_mask;
  logic [DATA_WIDTH-1:0] flip_data;
  logic [N-1:0]          unused_state_hi;

  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  out_last_reg, out_last_next;
  logic                  skid_valid_reg, skid_valid_next;
  logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
  logic                  skid_last_reg, skid_last_next;
  logic                  ready_reg;

  assign accept = s_axis_tvalid && ready_reg;

  // Generators advance on every accepted beat regardless of en, so the
  // random sequence is a pure function of the beat count.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [31:0]          lane_state;
    logic [LLR_WIDTH-1:0] llr_in;
    logic [LLR_WIDTH-1:0] llr_neg;

    ldpc_ber_tester_xorshift32 u_xorshift (
      .clk     (data_clk),
      .resetn  (data_resetn),
      .advance (accept),
      .seed    (lane_seed(SEED, gi)),
      .state   (lane_state)
    );

    assign llr_in  = s_axis_tdata[gi*LLR_WIDTH +: LLR_WIDTH];
    assign llr_neg = (llr_in == MOST_NEG) ? MOST_POS : (~llr_in + 1'b1);

    assign flip_mask[gi] = en && (lane_state[15:0] < threshold);
    assign flip_data[gi*LLR_WIDTH +: LLR_WIDTH] = flip_mask[gi] ? llr_neg : llr_in;
    assign unused_state_hi[gi] = ^lane_state[31:16];
  end

  // Skid buffer: the output register loads whenever it is empty or draining,
  // taking the skid entry first; otherwise an accepted beat parks in skid.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_last_next   = out_last_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_last_next  = skid_last_reg;
    if (!out_valid_reg || m_axis_tready) begin
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        out_last_next   = skid_last_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_valid_next = 1'b1;
        out_data_next  = flip_data;
        out_last_next  = s_axis_tlast;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = flip_data;
      skid_last_next  = s_axis_tlast;
    end
  end

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_last_reg   <= out_last_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_last_reg  <= skid_last_next;
      ready_reg      <= !skid_valid_next;
    end
  end

  assign s_axis_tready = ready_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tlast  = out_last_reg;

`ifdef LDPC_BER_FLIP_COUNT_EN
  logic [63:0] count_reg;
  logic [63:0] flip_pop;

  always_comb begin
    flip_pop = '0;
    for (int i = 0; i < N; i++) begin
      flip_pop = flip_pop + 64'(flip_mask[i]);
    end
  end

  // A clear coinciding with an accepted beat restarts the count at that beat.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      count_reg <= '0;
    end else if (clear_count) begin
      count_reg <= accept ? flip_pop : 64'd0;
    end else if (accept) begin
      count_reg <= count_reg + flip_pop;
    end
  end

  assign flip_count = count_reg;
`else
  logic unused_clear;
  assign unused_clear = clear_count;
  assign flip_count   = '0;
`endif

endmodule

// File: tb/tb_ldpc_ber_channel_flip.sv
// Scoreboard bench for ldpc_ber_channel_flip: independent xorshift lane model,
// expected beats queued on acceptance and compared when the DUT emits them.
`timescale 1ns/1ps
module tb_ldpc_ber_channel_flip;

  localparam int DW = 128;
  localparam int LW = 8;
  localparam int N  = DW / LW;
  localparam logic [31:0] SEED = 32'h1D872B41;
`ifdef LDPC_BER_FLIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          data_clk;
  logic          data_resetn;
  logic          en;
  logic [15:0]   threshold;
  logic          clear_count;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [63:0]   flip_count;

  ldpc_ber_channel_flip #(.SEED(SEED), .DATA_WIDTH(DW), .LLR_WIDTH(LW)) dut (
    .data_clk      (data_clk),
    .data_resetn   (data_resetn),
    .en            (en),
    .threshold     (threshold),
    .clear_count   (clear_count),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .flip_count    (flip_count)
  );

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  int vectors;
  int miscompares;

  logic [DW-1:0] exp_data_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] capture_q[$];
  bit            capture_on;
  logic [31:0]   model_st[N];
  logic [63:0]   model_cnt;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [7:0] sat_neg(input logic [7:0] v);
    if (v == 8'h80) return 8'h7F;
    return 8'(8'h00 - v);
  endfunction

  function automatic logic [DW-1:0] ramp_beat(input int k);
    logic [DW-1:0] d;
    for (int l = 0; l < N; l++) d[l*8 +: 8] = 8'(k * 7 + l * 29);
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model_st[i] = SEED ^ (32'(i) * 32'h9E3779B9);
    model_cnt = '0;
    exp_data_q.delete();
    exp_last_q.delete();
  endtask

  // Called at a falling edge with inputs settled; accounts for what the
  // next rising edge does, then advances to the following falling edge.
  task automatic cycle();
    logic [DW-1:0] exp_d;
    logic          exp_l;
    logic [63:0]   pop;
    logic [7:0]    lin;
    bit            acc;
    if (m_axis_tvalid && m_axis_tready) begin
      vectors++;
      if (exp_data_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat got=%h", m_axis_tdata);
      end else begin
        exp_d = exp_data_q.pop_front();
        exp_l = exp_last_q.pop_front();
        if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
          miscompares++;
          $display("FAIL beat_data got=%h last=%b expected=%h last=%b",
                   m_axis_tdata, m_axis_tlast, exp_d, exp_l);
        end
        if (capture_on) capture_q.push_back(m_axis_tdata);
      end
    end
    pop = '0;
    acc = s_axis_tvalid && s_axis_tready;
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        lin = s_axis_tdata[i*8 +: 8];
        if (en && (model_st[i][15:0] < threshold)) begin
          exp_d[i*8 +: 8] = sat_neg(lin);
          pop = pop + 64'd1;
        end else begin
          exp_d[i*8 +: 8] = lin;
        end
        model_st[i] = xs_next(model_st[i]);
      end
      exp_data_q.push_back(exp_d);
      exp_last_q.push_back(s_axis_tlast);
    end
    if (CNT_EN) begin
      if (clear_count) model_cnt = acc ? pop : 64'd0;
      else if (acc)    model_cnt = model_cnt + pop;
    end
    @(posedge data_clk);
    @(negedge data_clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit acc;
    bit done;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      acc = s_axis_tready;
      cycle();
      if (acc) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout ready=%b required=1", s_axis_tready);
    end
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int t = 0; t < 32 && exp_data_q.size() != 0; t++) cycle();
    vectors++;
    if (exp_data_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_data_q.size());
    end
  endtask

  task automatic check_count(input string name);
    vectors++;
    if (flip_count !== model_cnt) begin
      miscompares++;
      $display("FAIL %s flip_count=%0d required=%0d", name, flip_count, model_cnt);
    end
  endtask

  // Asynchronous assertion between edges, release on a falling edge.
  task automatic do_reset();
    capture_on = 1'b0;
    #2;
    data_resetn = 1'b0;
    #1;
    vectors++;
    if (flip_count !== 64'd0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset count=%0d valid=%b ready=%b required=0/0/0",
               flip_count, m_axis_tvalid, s_axis_tready);
    end
    @(posedge data_clk);
    @(negedge data_clk);
    data_resetn = 1'b1;
    model_reset();
    @(posedge data_clk);
    @(negedge data_clk);
  endtask

  task automatic test_reset();
    data_resetn   = 1'b0;
    en            = 1'b0;
    threshold     = 16'h0000;
    clear_count   = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    capture_on    = 1'b0;
    repeat (3) @(posedge data_clk);
    @(negedge data_clk);
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++; $display("FAIL reset_tready got=%b required=0", s_axis_tready);
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL reset_mvalid valid=%b last=%b required=0/0", m_axis_tvalid, m_axis_tlast);
    end
    vectors++;
    if (m_axis_tdata !== '0) begin
      miscompares++; $display("FAIL reset_mdata got=%h required=0", m_axis_tdata);
    end
    vectors++;
    if (flip_count !== 64'd0) begin
      miscompares++; $display("FAIL reset_count got=%0d required=0", flip_count);
    end
    data_resetn = 1'b1;
    model_reset();
    @(posedge data_clk);
    @(negedge data_clk);
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_tready got=%b required=1", s_axis_tready);
    end
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] d;
    en = 1'b1;
    threshold = 16'h0000;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      d = ramp_beat(k);
      send(d, 1'($urandom_range(0, 1)));
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d) begin
        miscompares++;
        $display("FAIL latency beat=%0d valid=%b data=%h required=1 %h", k, m_axis_tvalid, m_axis_tdata, d);
      end
    end
    drain();
    check_count("passthrough_count");
  endtask

  task automatic test_random_channel();
    en = 1'b1;
    threshold = 16'h8000;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 10000; k++) send(rand_beat(), 1'((k % 8) == 7));
    drain();
    check_count("half_rate_count");
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d;
    bit f0, f1;
    en = 1'b1;
    threshold = 16'hFFFF;
    m_axis_tready = 1'b1;
    for (int l = 0; l < N; l++) d[l*8 +: 8] = (l % 2 == 0) ? 8'h80 : 8'h05;
    f0 = (model_st[0][15:0] != 16'hFFFF);
    f1 = (model_st[1][15:0] != 16'hFFFF);
    send(d, 1'b1);
    vectors++;
    if (f0 && m_axis_tdata[7:0] !== 8'h7F) begin
      miscompares++; $display("FAIL sat_neg_80 got=%h required=7f", m_axis_tdata[7:0]);
    end
    vectors++;
    if (f1 && m_axis_tdata[15:8] !== 8'hFB) begin
      miscompares++; $display("FAIL neg_05 got=%h required=fb", m_axis_tdata[15:8]);
    end
    drain();
    check_count("saturation_count");
  endtask

  task automatic test_back_to_back();
    int kk;
    int accepted;
    bit acc;
    en = 1'b1;
    threshold = 16'h4000;
    m_axis_tready = 1'b0;
    kk = 0;
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      s_axis_tdata  = ramp_beat(500 + kk);
      s_axis_tlast  = 1'(kk % 2);
      s_axis_tvalid = 1'b1;
      acc = s_axis_tready;
      cycle();
      if (acc) begin
        kk++;
        accepted++;
      end
    end
    vectors++;
    if (accepted != 2 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_accept accepted=%0d ready=%b required=2 0", accepted, s_axis_tready);
    end
    m_axis_tready = 1'b1;
    for (int k = 0; k < 6; k++) send(ramp_beat(500 + kk + k), 1'((kk + k) % 2));
    drain();
    check_count("back_to_back_count");
  endtask

  task automatic test_en_independence();
    logic [DW-1:0] run_a[$];
    m_axis_tready = 1'b1;
    threshold = 16'h8000;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      capture_q.delete();
      capture_on = 1'b1;
      for (int k = 0; k < 100; k++) begin
        en = (r == 0 && k < 50) ? 1'b0 : 1'b1;
        send(ramp_beat(1000 + k), 1'b0);
      end
      drain();
      capture_on = 1'b0;
      if (r == 0) run_a = capture_q;
    end
    vectors++;
    if (run_a.size() != 100 || capture_q.size() != 100) begin
      miscompares++;
      $display("FAIL en_capture sizes=%0d/%0d required=100", run_a.size(), capture_q.size());
    end else begin
      for (int k = 50; k < 100; k++) begin
        vectors++;
        if (capture_q[k] !== run_a[k]) begin
          miscompares++;
          $display("FAIL en_independent beat=%0d got=%h required=%h", k, capture_q[k], run_a[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midburst();
    logic [DW-1:0] stim_d[40];
    logic          stim_l[40];
    logic [DW-1:0] run_a[$];
    for (int k = 0; k < 40; k++) begin
      stim_d[k] = rand_beat();
      stim_l[k] = 1'($urandom_range(0, 1));
    end
    en = 1'b1;
    threshold = 16'h8000;
    m_axis_tready = 1'b1;
    do_reset();
    capture_q.delete();
    capture_on = 1'b1;
    for (int k = 0; k < 25; k++) send(stim_d[k], stim_l[k]);
    run_a = capture_q;
    do_reset();
    capture_q.delete();
    capture_on = 1'b1;
    for (int k = 0; k < 40; k++) send(stim_d[k], stim_l[k]);
    drain();
    capture_on = 1'b0;
    for (int k = 0; k < run_a.size(); k++) begin
      vectors++;
      if (capture_q[k] !== run_a[k]) begin
        miscompares++;
        $display("FAIL replay beat=%0d got=%h required=%h", k, capture_q[k], run_a[k]);
      end
    end
    check_count("replay_count");
  endtask

  task automatic test_clear();
    int lows[$];
    en = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) lows.push_back(int'(model_st[i][15:0]));
    lows.sort();
    threshold = 16'(lows[2] + 1);
    clear_count = 1'b1;
    send(ramp_beat(77), 1'b1);
    clear_count = 1'b0;
    s_axis_tvalid = 1'b0;
    check_count("clear_with_beat");
    drain();
    clear_count = 1'b1;
    cycle();
    clear_count = 1'b0;
    check_count("clear_idle");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_passthrough();
    test_random_channel();
    test_saturation();
    test_back_to_back();
    test_en_independence();
    test_reset_midburst();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

endmodule
